// File: rtl/adder_tree_sat_pkg.sv
// Shared constants and helpers for the saturating adder tree: tree depth and
// the numeric range bounds of a WIDTH-bit result in signed or unsigned mode.
package adder_pkg;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  function automatic logic signed [63:0] smin_f(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic signed [63:0] smax_f(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] umin_f(input int w);
    return (w > 0) ? 64'sd0 : 64'sd0;
  endfunction

  function automatic logic signed [63:0] umax_f(input int w);
    return (64'sd1 <<< w) - 64'sd1;
  endfunction

endpackage

// File: rtl/adder_tree_sat_if.sv
// Valid/ready sample and result channels of the adder tree, with per-sample mode bits.
interface adder_tree_sat_if #(
  parameter int WIDTH = 12,
  parameter int LANES = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*WIDTH-1:0]   in_data;
  logic                     signed_mode;
  logic                     sat_en;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_ovf;

  modport master (
    output in_valid, in_data, signed_mode, sat_en, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, signed_mode, sat_en, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/adder_tree_sat_clip.sv
// Range check and saturate/wrap of a full-precision tree sum down to WIDTH bits.
module sat_clip
  import adder_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int SW    = 14
) (
  input  logic [SW-1:0]    sum_i,
  input  logic             signed_i,
  input  logic             sat_i,
  output logic [WIDTH-1:0] data_o,
  output logic             ovf_o
);

  logic signed [63:0] wide_s;
  logic signed [63:0] lo_s;
  logic signed [63:0] hi_s;

  // Interpret the sum in the sample's mode and pick that mode's bounds
  always_comb begin
    wide_s = 64'sd0;
    lo_s   = 64'sd0;
    hi_s   = 64'sd0;
    if (signed_i) begin
      wide_s = {{(64-SW){sum_i[SW-1]}}, sum_i};
      lo_s   = smin_f(WIDTH);
      hi_s   = smax_f(WIDTH);
    end else begin
      wide_s = {{(64-SW){1'b0}}, sum_i};
      lo_s   = umin_f(WIDTH);
      hi_s   = umax_f(WIDTH);
    end
  end

  // Overflow flag is independent of sat_i; only the data path clips
  always_comb begin
    ovf_o  = 1'b0;
    data_o = wide_s[WIDTH-1:0];
    if (wide_s > hi_s) begin
      ovf_o = 1'b1;
      if (sat_i) begin
        data_o = hi_s[WIDTH-1:0];
      end else begin
        data_o = wide_s[WIDTH-1:0];
      end
    end else if (wide_s < lo_s) begin
      ovf_o = 1'b1;
      if (sat_i) begin
        data_o = lo_s[WIDTH-1:0];
      end else begin
        data_o = wide_s[WIDTH-1:0];
      end
    end else begin
      ovf_o  = 1'b0;
      data_o = wide_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/adder_tree_sat.sv
// Pipelined LANES-operand adder tree with one register per tree level and a
// saturating/wrapping output register, stalled as a whole by out_ready.
module adder_tree_sat
  import adder_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int LANES = 4
) (
  input logic             clk,
  input logic             rst_n,
  adder_tree_sat_if.slave bus
);

  localparam int S  = clog2_f(LANES);
  localparam int SW = WIDTH + S;

  // Heap-indexed tree: node i sums nodes 2i and 2i+1; leaves LANES..2*LANES-1
  // are the extended inputs, nodes 1..LANES-1 are registers, node 1 is the root.
  logic [SW-1:0]    node_s [1:2*LANES-1];
  logic [SW-1:0]    tree_d [1:LANES-1];
  logic [SW-1:0]    tree_q [1:LANES-1];
  logic [S-1:0]     vld_q;
  logic [S-1:0]     sgn_q;
  logic [S-1:0]     sat_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_ovf_q;
  logic [WIDTH-1:0] clip_data_s;
  logic             clip_ovf_s;
  logic             advance_s;

  assign advance_s     = bus.out_ready | ~out_valid_q;
  assign bus.in_ready  = advance_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

  // Leaves extended by the incoming sample's mode; inner nodes from registers
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (bus.signed_mode) begin
        node_s[LANES+i] = {{S{bus.in_data[i*WIDTH+WIDTH-1]}}, bus.in_data[i*WIDTH +: WIDTH]};
      end else begin
        node_s[LANES+i] = {{S{1'b0}}, bus.in_data[i*WIDTH +: WIDTH]};
      end
    end
    for (int i = 1; i < LANES; i++) begin
      node_s[i] = tree_q[i];
    end
  end

  // Next value of every tree register
  always_comb begin
    for (int i = 1; i < LANES; i++) begin
      tree_d[i] = node_s[2*i] + node_s[2*i+1];
    end
  end

  // Tree data and per-level mode bits; no reset needed on data
  always_ff @(posedge clk) begin
    if (advance_s) begin
      tree_q   <= tree_d;
      sgn_q[0] <= bus.signed_mode;
      sat_q[0] <= bus.sat_en;
      for (int k = 1; k < S; k++) begin
        sgn_q[k] <= sgn_q[k-1];
        sat_q[k] <= sat_q[k-1];
      end
    end
  end

  sat_clip #(
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_clip (
    .sum_i    (tree_q[1]),
    .signed_i (sgn_q[S-1]),
    .sat_i    (sat_q[S-1]),
    .data_o   (clip_data_s),
    .ovf_o    (clip_ovf_s)
  );

  // Valid chain and output register; bubbles leave the last result in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= {S{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
      out_ovf_q   <= 1'b0;
    end else if (advance_s) begin
      vld_q[0] <= bus.in_valid;
      for (int k = 1; k < S; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      out_valid_q <= vld_q[S-1];
      if (vld_q[S-1]) begin
        out_data_q <= clip_data_s;
        out_ovf_q  <= clip_ovf_s;
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_sat.sv
// Self-checking bench: directed corner sums plus randomized streams scored
// against an integer-arithmetic model of the sum/range/clip rules.
module tb_adder_tree_sat;

  localparam int W = 12;
  localparam int L = 4;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;
  int   n_acc;
  int   n_pop;
  logic [W:0] exp_q [$];

  adder_tree_sat_if #(.WIDTH(W), .LANES(L)) bus ();

  adder_tree_sat #(.WIDTH(W), .LANES(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer sum, then range check and clip/wrap
  function automatic logic [W:0] ref_f(input logic [L*W-1:0] d, input logic sg, input logic st);
    longint sum, v, lo, hi, r;
    logic   ovf;
    sum = 0;
    for (int i = 0; i < L; i++) begin
      v = longint'(d[i*W +: W]);
      if (sg && v >= (longint'(1) << (W - 1))) v = v - (longint'(1) << W);
      sum = sum + v;
    end
    lo  = sg ? -(longint'(1) << (W - 1)) : longint'(0);
    hi  = sg ? (longint'(1) << (W - 1)) - 1 : (longint'(1) << W) - 1;
    ovf = (sum < lo) || (sum > hi);
    r   = sum;
    if (st && sum > hi) r = hi;
    else if (st && sum < lo) r = lo;
    return {ovf, r[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_lane();
    case ($urandom_range(0, 4))
      0: return 12'h800;
      1: return 12'h7FF;
      2: return 12'hFFF;
      3: return 12'h000;
      default: return 12'($urandom);
    endcase
  endfunction

  function automatic logic [L*W-1:0] rand_data();
    logic [L*W-1:0] d;
    for (int i = 0; i < L; i++) d[i*W +: W] = rand_lane();
    return d;
  endfunction

  // One clock: score handshakes at the falling edge, end just after the rising edge
  task automatic step();
    logic [W:0] e;
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 32'(bus.out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_data", 32'(bus.out_data), 32'(e[W-1:0]));
        check_eq("out_ovf", 32'(bus.out_ovf), 32'(e[W]));
      end
    end
    if (bus.out_valid && !bus.out_ready) check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(ref_f(bus.in_data, bus.signed_mode, bus.sat_en));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() > 0 || bus.out_valid); i++) step();
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic directed(input string tag, input logic [L*W-1:0] d, input logic sg,
                          input logic st, input logic [W-1:0] ed, input logic eo);
    bus.in_valid    = 1'b1;
    bus.in_data     = d;
    bus.signed_mode = sg;
    bus.sat_en      = st;
    bus.out_ready   = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    check_eq({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    step();
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(bus.out_data), 32'(ed));
    check_eq({tag, "_ovf"}, 32'(bus.out_ovf), 32'(eo));
    step();
  endtask

  initial begin
    int a0, p0;
    n_total = 0; n_bad = 0; n_acc = 0; n_pop = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.signed_mode = 1'b0;
    bus.sat_en = 1'b0; bus.out_ready = 1'b0;
    #12;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
    check_eq("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    #10 rst_n = 1'b1;
    step();

    directed("sgn_min", {12'h000, 12'h000, 12'hFFF, 12'h801}, 1'b1, 1'b1, 12'h800, 1'b0);
    directed("sgn_sat", {4{12'h800}}, 1'b1, 1'b1, 12'h800, 1'b1);
    directed("sgn_wrap", {4{12'h800}}, 1'b1, 1'b0, 12'h000, 1'b1);
    directed("uns_sat", {4{12'hFFF}}, 1'b0, 1'b1, 12'hFFF, 1'b1);
    directed("uns_wrap", {4{12'hFFF}}, 1'b0, 1'b0, 12'hFFC, 1'b1);
    directed("uns_small", {12'h000, 12'h000, 12'h0EA, 12'h001}, 1'b0, 1'b0, 12'h0EB, 1'b0);

    // Alternating modes on identical data
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.in_data = {4{12'hFFF}};
      bus.signed_mode = ~i[0]; bus.sat_en = 1'b1;
      step();
    end
    drain();

    // Eight back-to-back samples with a three-cycle consumer stall
    a0 = n_acc; p0 = n_pop;
    for (int c = 0; c < 40 && (n_acc - a0) < 8; c++) begin
      bus.in_valid = 1'b1; bus.in_data = rand_data();
      bus.signed_mode = 1'($urandom); bus.sat_en = 1'($urandom);
      bus.out_ready = !(c >= 4 && c <= 6);
      step();
    end
    drain();
    check_eq("stream_count", 32'(n_pop - p0), 32'd8);

    // Reset with the output full and more samples in flight
    bus.out_ready = 1'b0; bus.signed_mode = 1'b0; bus.sat_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = rand_data();
      step();
    end
    bus.in_valid = 1'b0;
    check_eq("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid_rst_data", 32'(bus.out_data), 32'd0);
    check_eq("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("no_stale", 32'(bus.out_valid), 32'd0);
    end
    directed("post_rst", {12'h000, 12'h000, 12'hFFF, 12'h801}, 1'b1, 1'b1, 12'h800, 1'b0);

    // Random traffic with random bubbles and back-pressure
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data = rand_data();
      bus.signed_mode = 1'($urandom); bus.sat_en = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
